// File: rtl/axil_delay_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axil_delay_bridge
// Brief    : AXI4-Lite pass-through that inserts a fixed or LFSR-random delay
//            before forwarding each read and write transaction downstream.
// Revision : 1.0 - initial release
// ============================================================================
module axil_delay_bridge #(
  parameter int          DLY_BITS  = 4,
  parameter int          RAND_EN   = 1,
  parameter int          FIX_DELAY = 0,
  parameter logic [7:0]  SEED      = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  // upstream read
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  input  logic        s_rready,
  // upstream write
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [7:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic        s_bvalid,
  input  logic        s_bready,
  // downstream read
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  output logic        m_rready,
  // downstream write
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [7:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic        m_bvalid,
  output logic        m_bready
);

  localparam logic [7:0]          c_SEED = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [DLY_BITS-1:0] c_ONE  = {{(DLY_BITS-1){1'b0}}, 1'b1};

  localparam logic [2:0] c_R_IDLE  = 3'd0;
  localparam logic [2:0] c_R_WAIT  = 3'd1;
  localparam logic [2:0] c_R_ADDR  = 3'd2;
  localparam logic [2:0] c_R_DATA  = 3'd3;
  localparam logic [2:0] c_R_RESP  = 3'd4;

  localparam logic [2:0] c_W_IDLE  = 3'd0;
  localparam logic [2:0] c_W_WAIT  = 3'd1;
  localparam logic [2:0] c_W_FWD   = 3'd2;
  localparam logic [2:0] c_W_BRESP = 3'd3;
  localparam logic [2:0] c_W_RESP  = 3'd4;

  logic [7:0]          r_lfsr;
  logic [DLY_BITS-1:0] w_delay;

  logic [2:0]          r_rstate, w_rstate_nxt;
  logic [DLY_BITS-1:0] r_rcnt;
  logic [31:0]         r_araddr, r_rdata;
  logic                w_ar_hs;

  logic [2:0]          r_wstate, w_wstate_nxt;
  logic [DLY_BITS-1:0] r_wcnt;
  logic [31:0]         r_awaddr, r_wdata;
  logic [7:0]          r_wstrb;
  logic                r_aw_got, r_w_got, r_aw_done, r_w_done;
  logic                w_aw_hs, w_w_hs, w_both_got, w_fwd_done;

  // Fibonacci LFSR, taps 8,6,5,4; free-running so delays vary with traffic timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= c_SEED;
    else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  if (RAND_EN != 0) begin : g_rand_dly
    assign w_delay = r_lfsr[DLY_BITS-1:0];
  end else begin : g_fix_dly
    localparam logic [DLY_BITS-1:0] c_FIX = DLY_BITS'(FIX_DELAY);
    assign w_delay = c_FIX;
  end

  // ---------------- read path ----------------
  assign w_ar_hs  = (r_rstate == c_R_IDLE) & s_arvalid;
  assign m_araddr = r_araddr;
  assign s_rdata  = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= c_R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      c_R_IDLE: if (s_arvalid)       w_rstate_nxt = c_R_WAIT;
      c_R_WAIT: if (r_rcnt == '0)    w_rstate_nxt = c_R_ADDR;
      c_R_ADDR: if (m_arready)       w_rstate_nxt = c_R_DATA;
      c_R_DATA: if (m_rvalid)        w_rstate_nxt = c_R_RESP;
      c_R_RESP: if (s_rready)        w_rstate_nxt = c_R_IDLE;
      default:                       w_rstate_nxt = c_R_IDLE;
    endcase
  end

  // Ready is masked by rst so every handshake output reads 0 while reset is held
  always_comb begin
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_rvalid  = 1'b0;
    case (r_rstate)
      c_R_IDLE: s_arready = ~rst;
      c_R_ADDR: m_arvalid = 1'b1;
      c_R_DATA: m_rready  = 1'b1;
      c_R_RESP: s_rvalid  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rcnt   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_araddr <= s_araddr;
        r_rcnt   <= w_delay;
      end else if ((r_rstate == c_R_WAIT) && (r_rcnt != '0)) begin
        r_rcnt   <= r_rcnt - c_ONE;
      end
      if ((r_rstate == c_R_DATA) && m_rvalid) r_rdata <= m_rdata;
    end
  end

  // ---------------- write path ----------------
  assign w_aw_hs    = (r_wstate == c_W_IDLE) & ~r_aw_got & s_awvalid;
  assign w_w_hs     = (r_wstate == c_W_IDLE) & ~r_w_got  & s_wvalid;
  assign w_both_got = (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
  assign w_fwd_done = (r_aw_done | m_awready) & (r_w_done | m_wready);
  assign m_awaddr   = r_awaddr;
  assign m_wdata    = r_wdata;
  assign m_wstrb    = r_wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= c_W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      c_W_IDLE:  if (w_both_got)    w_wstate_nxt = c_W_WAIT;
      c_W_WAIT:  if (r_wcnt == '0)  w_wstate_nxt = c_W_FWD;
      c_W_FWD:   if (w_fwd_done)    w_wstate_nxt = c_W_BRESP;
      c_W_BRESP: if (m_bvalid)      w_wstate_nxt = c_W_RESP;
      c_W_RESP:  if (s_bready)      w_wstate_nxt = c_W_IDLE;
      default:                      w_wstate_nxt = c_W_IDLE;
    endcase
  end

  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_bvalid  = 1'b0;
    case (r_wstate)
      c_W_IDLE: begin
        s_awready = ~rst & ~r_aw_got;
        s_wready  = ~rst & ~r_w_got;
      end
      c_W_FWD: begin
        m_awvalid = ~r_aw_done;
        m_wvalid  = ~r_w_done;
      end
      c_W_BRESP: m_bready = 1'b1;
      c_W_RESP:  s_bvalid = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wcnt    <= '0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awaddr <= s_awaddr;
        r_aw_got <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
        r_w_got <= 1'b1;
      end
      if ((r_wstate == c_W_IDLE) && w_both_got) begin
        r_wcnt <= w_delay;
      end else if ((r_wstate == c_W_WAIT) && (r_wcnt != '0)) begin
        r_wcnt <= r_wcnt - c_ONE;
      end
      if (r_wstate == c_W_FWD) begin
        if (w_fwd_done) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          if (m_awready) r_aw_done <= 1'b1;
          if (m_wready)  r_w_done  <= 1'b1;
        end
      end
      if ((r_wstate == c_W_RESP) && s_bready) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_delay_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_delay_bridge
// Brief    : Directed checks on a fixed-delay bridge, then randomized traffic on
//            an LFSR-delay bridge against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_delay_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // ---------------- main random DUT (LFSR delay, seed 01) ----------------
  logic        rst;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata, m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0]  s_wstrb, m_wstrb;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready, s_wvalid, s_wready;
  logic s_bvalid, s_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

  axil_delay_bridge #(.DLY_BITS(4), .RAND_EN(1), .FIX_DELAY(0), .SEED(8'h01)) u_dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  // ---------------- SEED=0 instance, shares main stimulus ----------------
  logic [31:0] z_rdata, z_araddr, z_awaddr, z_wdata;
  logic [7:0]  z_wstrb;
  logic z_arready, z_rvalid, z_awready, z_wready, z_bvalid;
  logic z_arvalid, z_rready, z_awvalid, z_wvalid, z_bready;

  axil_delay_bridge #(.DLY_BITS(4), .RAND_EN(1), .FIX_DELAY(0), .SEED(8'h00)) u_s0 (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(z_arready),
    .s_rdata(z_rdata), .s_rvalid(z_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(z_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(z_wready),
    .s_bvalid(z_bvalid), .s_bready(s_bready),
    .m_araddr(z_araddr), .m_arvalid(z_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(z_rready),
    .m_awaddr(z_awaddr), .m_awvalid(z_awvalid), .m_awready(m_awready),
    .m_wdata(z_wdata), .m_wstrb(z_wstrb), .m_wvalid(z_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(z_bready)
  );

  // ---------------- fixed-delay instance (delay 3) for directed timing ----------------
  logic        f_rst;
  logic [31:0] f_s_araddr, f_s_rdata, f_s_awaddr, f_s_wdata, f_m_araddr, f_m_rdata, f_m_awaddr, f_m_wdata;
  logic [7:0]  f_s_wstrb, f_m_wstrb;
  logic f_s_arvalid, f_s_arready, f_s_rvalid, f_s_rready, f_s_awvalid, f_s_awready, f_s_wvalid, f_s_wready;
  logic f_s_bvalid, f_s_bready, f_m_arvalid, f_m_arready, f_m_rvalid, f_m_rready;
  logic f_m_awvalid, f_m_awready, f_m_wvalid, f_m_wready, f_m_bvalid, f_m_bready;

  axil_delay_bridge #(.DLY_BITS(4), .RAND_EN(0), .FIX_DELAY(3), .SEED(8'h5A)) u_fix (
    .clk(clk), .rst(f_rst),
    .s_araddr(f_s_araddr), .s_arvalid(f_s_arvalid), .s_arready(f_s_arready),
    .s_rdata(f_s_rdata), .s_rvalid(f_s_rvalid), .s_rready(f_s_rready),
    .s_awaddr(f_s_awaddr), .s_awvalid(f_s_awvalid), .s_awready(f_s_awready),
    .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wvalid(f_s_wvalid), .s_wready(f_s_wready),
    .s_bvalid(f_s_bvalid), .s_bready(f_s_bready),
    .m_araddr(f_m_araddr), .m_arvalid(f_m_arvalid), .m_arready(f_m_arready),
    .m_rdata(f_m_rdata), .m_rvalid(f_m_rvalid), .m_rready(f_m_rready),
    .m_awaddr(f_m_awaddr), .m_awvalid(f_m_awvalid), .m_awready(f_m_awready),
    .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb), .m_wvalid(f_m_wvalid), .m_wready(f_m_wready),
    .m_bvalid(f_m_bvalid), .m_bready(f_m_bready)
  );

  task automatic directed_fixed();
    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("f_rst_flags", {f_s_arready, f_s_awready, f_s_wready, f_m_arvalid, f_m_rready,
                        f_s_rvalid, f_m_awvalid, f_m_wvalid, f_m_bready, f_s_bvalid}, 32'd0);
    chk("f_rst_araddr", f_m_araddr, 32'd0);
    chk("f_rst_rdata", f_s_rdata, 32'd0);
    f_rst = 1'b0;
    #1;
    chk("f_idle_arready", f_s_arready, 32'd1);
    repeat (9) @(negedge clk);

    // read, delay 3: m_arvalid first high 5 cycles after AR accept
    f_s_arvalid = 1'b1; f_s_araddr = 32'h8000_0000;
    @(negedge clk);
    f_s_arvalid = 1'b0;
    chk("rd_arready_busy", f_s_arready, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      chk("rd_arvalid_timing", f_m_arvalid, (k == 5) ? 32'd1 : 32'd0);
    end
    chk("rd_m_araddr", f_m_araddr, 32'h8000_0000);
    f_m_arready = 1'b1;
    @(negedge clk);
    f_m_arready = 1'b0;
    chk("rd_arvalid_drop", f_m_arvalid, 32'd0);
    chk("rd_rready", f_m_rready, 32'd1);
    f_m_rvalid = 1'b1; f_m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    f_m_rvalid = 1'b0; f_m_rdata = 32'd0;
    for (int i = 0; i < 5; i++) begin
      chk("rd_rvalid_hold", f_s_rvalid, 32'd1);
      chk("rd_rdata_hold", f_s_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    chk("rd_rvalid_still", f_s_rvalid, 32'd1);
    f_s_rready = 1'b1;
    @(negedge clk);
    f_s_rready = 1'b0;
    chk("rd_rvalid_done", f_s_rvalid, 32'd0);
    chk("rd_back_idle", f_s_arready, 32'd1);

    // write: AW at cycle 0, W at cycle 2, delay 3 -> forward at cycle 7
    f_s_awvalid = 1'b1; f_s_awaddr = 32'h8000_0100;
    @(negedge clk);
    f_s_awvalid = 1'b0;
    chk("wr_awready_got", f_s_awready, 32'd0);
    chk("wr_wready_open", f_s_wready, 32'd1);
    @(negedge clk);
    f_s_wvalid = 1'b1; f_s_wdata = 32'h1234_5678; f_s_wstrb = 8'h0F;
    @(negedge clk);
    f_s_wvalid = 1'b0;
    chk("wr_wready_got", f_s_wready, 32'd0);
    for (int c = 3; c <= 6; c++) begin
      chk("wr_wait_valids", {f_m_awvalid, f_m_wvalid}, 32'd0);
      @(negedge clk);
    end
    chk("wr_fwd_valids", {f_m_awvalid, f_m_wvalid}, 32'd3);
    chk("wr_awaddr", f_m_awaddr, 32'h8000_0100);
    chk("wr_wdata", f_m_wdata, 32'h1234_5678);
    chk("wr_wstrb", f_m_wstrb, 32'h0F);
    f_m_awready = 1'b1;
    @(negedge clk);
    f_m_awready = 1'b0;
    chk("wr_cycle8_valids", {f_m_awvalid, f_m_wvalid}, 32'd1);
    @(negedge clk);
    chk("wr_cycle9_valids", {f_m_awvalid, f_m_wvalid}, 32'd1);
    f_m_wready = 1'b1;
    @(negedge clk);
    f_m_wready = 1'b0;
    chk("wr_cycle10_valids", {f_m_awvalid, f_m_wvalid}, 32'd0);
    chk("wr_bready", f_m_bready, 32'd1);
    chk("wr_bvalid_early", f_s_bvalid, 32'd0);
    f_m_bvalid = 1'b1;
    @(negedge clk);
    f_m_bvalid = 1'b0;
    chk("wr_bready_drop", f_m_bready, 32'd0);
    chk("wr_s_bvalid", f_s_bvalid, 32'd1);
    f_s_bready = 1'b1;
    @(negedge clk);
    f_s_bready = 1'b0;
    chk("wr_single_bvalid", f_s_bvalid, 32'd0);
    chk("wr_back_idle", {f_s_awready, f_s_wready}, 32'd3);

    // async reset with read in data phase and write in its countdown
    f_s_arvalid = 1'b1; f_s_araddr = 32'h8000_0008;
    @(negedge clk);
    f_s_arvalid = 1'b0;
    repeat (3) @(negedge clk);
    f_s_awvalid = 1'b1; f_s_awaddr = 32'h8000_0200;
    f_s_wvalid = 1'b1; f_s_wdata = 32'hA5A5_5A5A; f_s_wstrb = 8'hFF;
    @(negedge clk);
    f_s_awvalid = 1'b0; f_s_wvalid = 1'b0;
    chk("rst_pre_arvalid", f_m_arvalid, 32'd1);
    f_m_arready = 1'b1;
    @(negedge clk);
    f_m_arready = 1'b0;
    @(negedge clk);
    chk("rst_pre_rready", f_m_rready, 32'd1);
    chk("rst_pre_wwait", {f_m_awvalid, f_m_wvalid, f_s_awready}, 32'd0);
    #2 f_rst = 1'b1;
    #1;
    chk("async_rst_flags", {f_s_arready, f_s_awready, f_s_wready, f_m_arvalid, f_m_rready,
                            f_s_rvalid, f_m_awvalid, f_m_wvalid, f_m_bready, f_s_bvalid}, 32'd0);
    chk("async_rst_araddr", f_m_araddr, 32'd0);
    chk("async_rst_awaddr", f_m_awaddr, 32'd0);
    chk("async_rst_wdata", f_m_wdata, 32'd0);
    chk("async_rst_wstrb", f_m_wstrb, 32'd0);
    @(negedge clk);
    f_rst = 1'b0;
    #1;
    f_s_arvalid = 1'b1; f_s_araddr = 32'h8000_0004;
    @(negedge clk);
    f_s_arvalid = 1'b0;
    for (int i = 0; i < 20 && !f_m_arvalid; i++) @(negedge clk);
    chk("post_rst_arvalid", f_m_arvalid, 32'd1);
    chk("post_rst_araddr", f_m_araddr, 32'h8000_0004);
    f_m_arready = 1'b1;
    @(negedge clk);
    f_m_arready = 1'b0;
    f_m_rvalid = 1'b1; f_m_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    f_m_rvalid = 1'b0;
    chk("post_rst_rvalid", f_s_rvalid, 32'd1);
    chk("post_rst_rdata", f_s_rdata, 32'hCAFE_F00D);
    chk("post_rst_no_write", {f_m_awvalid, f_m_wvalid, f_s_bvalid}, 32'd0);
    f_s_rready = 1'b1;
    @(negedge clk);
    f_s_rready = 1'b0;
    chk("post_rst_idle", {f_s_arready, f_s_awready, f_s_wready}, 32'd7);
  endtask

  // ---------------- transaction-level model of the random DUT ----------------
  logic [7:0]  mlfsr;
  int          cyc;
  bit          rd_busy, rd_addr_done, rd_data_got, rd_gap_seen;
  int          rd_go, rd_acc, rd_exp_gap, rd_count;
  logic [31:0] rd_addr, rd_data;
  bit          aw_got, w_got, wr_armed, aw_done, w_done, b_got;
  int          wr_go, wr_count;
  logic [31:0] wr_addr, wr_data;
  logic [7:0]  wr_strb;
  // bench master/slave agents
  bit          ar_pend, aw_pend, w_pend, slv_r, slv_aw, slv_w, sl_rvalid, sl_bvalid;
  logic [31:0] ar_addr, aw_addr, w_data, sl_rdata;
  logic [7:0]  w_strb;

  task automatic run_random(input int ncyc);
    bit e_arready, e_arvalid, e_rready, e_rvalid, e_awready, e_wready;
    bit e_awvalid, e_wvalid, e_bready, e_bvalid, drain;
    bit ar_hs, ar_m_hs, r_m_hs, r_s_hs, aw_hs, w_hs, aw_m_hs, w_m_hs, b_m_hs, b_s_hs;
    int gap;
    for (int n = 0; n < ncyc; n++) begin
      drain = (n >= ncyc - 100);
      e_arready = !rd_busy;
      e_arvalid = rd_busy && !rd_addr_done && (cyc >= rd_go);
      e_rready  = rd_busy && rd_addr_done && !rd_data_got;
      e_rvalid  = rd_data_got;
      e_awready = !wr_armed && !aw_got;
      e_wready  = !wr_armed && !w_got;
      e_awvalid = wr_armed && (cyc >= wr_go) && !aw_done;
      e_wvalid  = wr_armed && (cyc >= wr_go) && !w_done;
      e_bready  = wr_armed && aw_done && w_done && !b_got;
      e_bvalid  = b_got;

      chk("s_arready", s_arready, e_arready);
      chk("m_arvalid", m_arvalid, e_arvalid);
      chk("m_araddr", m_araddr, rd_addr);
      chk("m_rready", m_rready, e_rready);
      chk("s_rvalid", s_rvalid, e_rvalid);
      chk("s_rdata", s_rdata, rd_data);
      chk("s_awready", s_awready, e_awready);
      chk("s_wready", s_wready, e_wready);
      chk("m_awvalid", m_awvalid, e_awvalid);
      chk("m_wvalid", m_wvalid, e_wvalid);
      chk("m_awaddr", m_awaddr, wr_addr);
      chk("m_wdata", m_wdata, wr_data);
      chk("m_wstrb", m_wstrb, wr_strb);
      chk("m_bready", m_bready, e_bready);
      chk("s_bvalid", s_bvalid, e_bvalid);
      if (n < 300) begin
        chk("seed0_lfsr", u_s0.r_lfsr, mlfsr);
        chk("seed0_nonzero", u_s0.r_lfsr != 8'h00, 32'd1);
      end
      if (m_arvalid && rd_busy && !rd_gap_seen) begin
        gap = cyc - rd_acc;
        chk("ar_gap", gap, rd_exp_gap);
        chk("ar_gap_le_17", gap <= 17, 32'd1);
        if (rd_count == 0) chk("first_gap", gap, 32'd3);
        rd_gap_seen = 1'b1;
      end

      // drive bench master and slave
      if (!drain && !ar_pend && ($urandom % 3 == 0)) begin
        ar_pend = 1'b1; ar_addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      end
      if (!drain && !aw_pend && ($urandom % 3 == 0)) begin
        aw_pend = 1'b1; aw_addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      end
      if (!drain && !w_pend && ($urandom % 3 == 0)) begin
        w_pend = 1'b1; w_data = $urandom; w_strb = 8'($urandom);
      end
      if (slv_r && !sl_rvalid && (drain || ($urandom % 2 == 0))) begin
        sl_rvalid = 1'b1; sl_rdata = $urandom;
      end
      if (slv_aw && slv_w && !sl_bvalid && (drain || ($urandom % 2 == 0))) sl_bvalid = 1'b1;
      s_arvalid = ar_pend; s_araddr = ar_addr;
      s_awvalid = aw_pend; s_awaddr = aw_addr;
      s_wvalid  = w_pend;  s_wdata  = w_data; s_wstrb = w_strb;
      s_rready  = drain || ($urandom % 2 == 0);
      s_bready  = drain || ($urandom % 2 == 0);
      m_arready = drain || ($urandom % 2 == 0);
      m_awready = drain || ($urandom % 2 == 0);
      m_wready  = drain || ($urandom % 2 == 0);
      m_rvalid  = sl_rvalid; m_rdata = sl_rdata;
      m_bvalid  = sl_bvalid;

      // handshakes at the coming edge, from the model's view of the outputs
      ar_hs   = s_arvalid && e_arready;
      ar_m_hs = e_arvalid && m_arready;
      r_m_hs  = e_rready && m_rvalid;
      r_s_hs  = e_rvalid && s_rready;
      aw_hs   = s_awvalid && e_awready;
      w_hs    = s_wvalid && e_wready;
      aw_m_hs = e_awvalid && m_awready;
      w_m_hs  = e_wvalid && m_wready;
      b_m_hs  = e_bready && m_bvalid;
      b_s_hs  = e_bvalid && s_bready;

      if (ar_hs) begin
        rd_busy = 1'b1; rd_addr = s_araddr; rd_acc = cyc;
        rd_exp_gap = 2 + int'(mlfsr[3:0]); rd_go = cyc + rd_exp_gap;
        rd_addr_done = 1'b0; rd_data_got = 1'b0; rd_gap_seen = 1'b0; ar_pend = 1'b0;
      end
      if (ar_m_hs) begin rd_addr_done = 1'b1; slv_r = 1'b1; end
      if (r_m_hs)  begin rd_data_got = 1'b1; rd_data = m_rdata; slv_r = 1'b0; sl_rvalid = 1'b0; end
      if (r_s_hs)  begin rd_busy = 1'b0; rd_data_got = 1'b0; rd_count++; end

      if (aw_hs) begin aw_got = 1'b1; wr_addr = s_awaddr; aw_pend = 1'b0; end
      if (w_hs)  begin w_got = 1'b1; wr_data = s_wdata; wr_strb = s_wstrb; w_pend = 1'b0; end
      if (!wr_armed && aw_got && w_got) begin
        wr_armed = 1'b1; wr_go = cyc + 2 + int'(mlfsr[3:0]);
        aw_done = 1'b0; w_done = 1'b0; b_got = 1'b0;
      end
      if (aw_m_hs) begin aw_done = 1'b1; slv_aw = 1'b1; end
      if (w_m_hs)  begin w_done = 1'b1; slv_w = 1'b1; end
      if (b_m_hs)  begin b_got = 1'b1; sl_bvalid = 1'b0; slv_aw = 1'b0; slv_w = 1'b0; end
      if (b_s_hs)  begin
        wr_armed = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; b_got = 1'b0; wr_count++;
      end

      mlfsr = lfsr_next(mlfsr);
      cyc++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] lf;
    rst = 1'b1; f_rst = 1'b1;
    {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} = '0;
    {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
    s_araddr = '0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0; m_rdata = '0;
    {f_s_arvalid, f_s_rready, f_s_awvalid, f_s_wvalid, f_s_bready} = '0;
    {f_m_arready, f_m_rvalid, f_m_awready, f_m_wready, f_m_bvalid} = '0;
    f_s_araddr = '0; f_s_awaddr = '0; f_s_wdata = '0; f_s_wstrb = '0; f_m_rdata = '0;

    // pin the model LFSR against hand-stepped values from seed 01
    lf = 8'h01;
    repeat (4) lf = lfsr_next(lf);
    chk("model_lfsr_4", lf, 32'h11);
    repeat (2) lf = lfsr_next(lf);
    chk("model_lfsr_6", lf, 32'h47);

    directed_fixed();

    chk("main_rst_flags", {s_arready, s_awready, s_wready, m_arvalid, m_rready,
                           s_rvalid, m_awvalid, m_wvalid, m_bready, s_bvalid}, 32'd0);
    chk("seed0_reset_value", u_s0.r_lfsr, 32'h01);

    mlfsr = 8'h01; cyc = 0;
    {rd_busy, rd_addr_done, rd_data_got, rd_gap_seen} = '0;
    rd_go = 0; rd_acc = 0; rd_exp_gap = 0; rd_count = 0; rd_addr = '0; rd_data = '0;
    {aw_got, w_got, wr_armed, aw_done, w_done, b_got} = '0;
    wr_go = 0; wr_count = 0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    {slv_r, slv_aw, slv_w, sl_rvalid, sl_bvalid} = '0;
    sl_rdata = '0;
    // first cycle issues a read and a write together
    ar_pend = 1'b1; ar_addr = 32'h8000_0040;
    aw_pend = 1'b1; aw_addr = 32'h8000_0080;
    w_pend  = 1'b1; w_data  = 32'h0BAD_F00D; w_strb = 8'h3C;
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_random(1500);

    chk("end_rd_idle", s_arready, 32'd1);
    chk("end_wr_idle", {s_awready, s_wready}, 32'd3);
    chk("reads_ge_20", rd_count >= 20, 32'd1);
    chk("writes_ge_20", wr_count >= 20, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
